// File: rtl/rpt_pkg.sv
// Shared definitions for the result port writer: FSM state encoding,
// bus widths and the byte-order helper used when RPT_BYTE_SWAP_EN is defined.
package rpt_pkg;

    localparam int unsigned RPT_DATA_W  = 32;
    localparam int unsigned RPT_ADDR_W  = 30;
    localparam int unsigned RPT_COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_GAP   = 2'b10
    } rpt_state_e;

    // Reverse the byte order of a 32-bit word (big-endian value -> little-endian bus).
    function automatic logic [RPT_DATA_W-1:0] byte_swap32(input logic [RPT_DATA_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/rpt_fifo.sv
// Small synchronous FIFO buffering results ahead of the port writer.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// A push while full and a pop while empty are ignored.
module rpt_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];

    // Storage write; only slots between the pointers are ever read.
    // NOTE: the storage array has no reset on purpose -- occupancy is tracked by
    // the reset pointers/count, so clearing data words would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps count constant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_port_writer.sv
// Result port writer: buffers producer results in rpt_fifo and replays each one
// as a single-word memory write to PORT_ADDR, honouring mem_stall and forcing
// MIN_GAP idle cycles after every write.
// Optional build macro RPT_BYTE_SWAP_EN: when defined the write data is driven
// in little-endian byte order; otherwise the result is written unchanged.
module result_port_writer
    import rpt_pkg::*;
#(
    parameter logic [29:0] PORT_ADDR  = 30'd0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MIN_GAP    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        mem_stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic [7:0]  write_count
);

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [RPT_DATA_W-1:0]  w_head;
    logic [RPT_DATA_W-1:0]  w_head_bus;

    rpt_state_e             r_state;
    logic                   r_ready_en;
    logic                   r_pending;
    logic [3:0]             r_gap_cnt;
    logic [RPT_ADDR_W-1:0]  r_addr;
    logic [RPT_DATA_W-1:0]  r_data;
    logic                   r_wen;
    logic [RPT_COUNT_W-1:0] r_write_count;

    // The head leaves the FIFO on the edge that completes an unstalled write.
    assign w_push = in_valid && in_ready;
    assign w_pop  = (r_state == ST_WRITE) && !mem_stall;

`ifdef RPT_BYTE_SWAP_EN
    assign w_head_bus = byte_swap32(w_head);
`else
    assign w_head_bus = w_head;
`endif

    rpt_fifo #(
        .WIDTH (RPT_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Hold off the producer until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // Registered FIFO-occupied flag: decouples the FSM from the FIFO count and
    // gives the two-edge push-to-wen latency. It never lags a pop long enough to
    // matter because GAP always separates a pop from the next IDLE decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= !w_empty;
        end
    end

    // Write-sequencing FSM with registered port outputs and saturating counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_gap_cnt     <= '0;
            r_addr        <= PORT_ADDR;
            r_data        <= '0;
            r_wen         <= 1'b0;
            r_write_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending && !w_empty) begin
                        r_state <= ST_WRITE;
                        r_wen   <= 1'b1;
                        r_addr  <= PORT_ADDR;
                        r_data  <= w_head_bus;
                    end
                end
                ST_WRITE: begin
                    if (!mem_stall) begin
                        r_state   <= ST_GAP;
                        r_wen     <= 1'b0;
                        r_gap_cnt <= 4'(MIN_GAP - 1);
                        if (r_write_count != {RPT_COUNT_W{1'b1}}) begin
                            r_write_count <= r_write_count + RPT_COUNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_ready_en && !w_full;
    assign busy        = !w_empty || (r_state != ST_IDLE);
    assign addr        = r_addr;
    assign data        = r_data;
    assign wen         = r_wen;
    assign write_count = r_write_count;

endmodule

// File: tb/tb_result_port_writer.sv
// Self-checking bench for result_port_writer: directed latency, stall, fill,
// reset and saturation scenarios plus randomized traffic against a
// queue-based scoreboard of expected writes.
`timescale 1ns/1ps
module tb_result_port_writer;

    localparam logic [29:0] P_ADDR = 30'd0;
    localparam int          DEPTH  = 4;
    localparam int          GAP    = 1;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic [31:0] in_data   = '0;
    logic        mem_stall = 1'b0;
    logic        in_ready;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        busy;
    logic [7:0]  write_count;

    always #5 clk = ~clk;

    result_port_writer #(
        .PORT_ADDR  (P_ADDR),
        .FIFO_DEPTH (DEPTH),
        .MIN_GAP    (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_stall   (mem_stall),
        .addr        (addr),
        .data        (data),
        .wen         (wen),
        .busy        (busy),
        .write_count (write_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    int          exp_wc;
    bit          rdy_en;
    int          completions;
    bit          last_push;
    bit          prev_wen;
    bit          prev_stall;
    int          low_run;
    bit          seen_pulse;
    logic        smp_wen;
    logic        smp_ready;
    logic [31:0] smp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_bus(input logic [31:0] d);
`ifdef RPT_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic s);
        bit exp_ready;
        bit done;
        in_valid  = v;
        in_data   = d;
        mem_stall = s;
        @(negedge clk);
        exp_ready = rdy_en && (exp_q.size() < DEPTH);
        smp_wen   = wen;
        smp_ready = in_ready;
        smp_data  = data;
        check("in_ready", in_ready, exp_ready);
        check("write_count", write_count, exp_wc);
        check("addr", addr, P_ADDR);
        if (exp_q.size() > 0) check("busy", busy, 1);
        if (wen) begin
            if (exp_q.size() == 0) check("stale_write", wen, 0);
            else check("wr_data", data, exp_bus(exp_q[0]));
            if (!prev_wen && seen_pulse) check("gap_len", low_run >= GAP + 1, 1);
        end
        if (prev_wen && prev_stall) check("stall_hold", wen, 1);
        if (prev_wen && !prev_stall) check("wen_drop", wen, 0);
        if (wen) begin
            low_run    = 0;
            seen_pulse = 1;
        end else begin
            low_run++;
        end
        last_push  = v && exp_ready;
        done       = wen && !s && (exp_q.size() > 0);
        prev_wen   = wen;
        prev_stall = s;
        @(posedge clk);
        if (done) begin
            void'(exp_q.pop_front());
            if (exp_wc < 255) exp_wc++;
            completions++;
        end
        if (last_push) exp_q.push_back(d);
        rdy_en = 1;
        #1;
    endtask

    // Assert reset (asynchronously, mid-cycle), check reset values, release.
    task automatic do_reset();
        in_valid  = 0;
        mem_stall = 0;
        rst       = 0;
        #1;
        check("rst_wen_now", wen, 0);
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_wen", wen, 0);
        check("rst_addr", addr, P_ADDR);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_wc", write_count, 0);
        @(posedge clk);
        #1;
        rst = 1;
        exp_q.delete();
        exp_wc      = 0;
        rdy_en      = 0;
        completions = 0;
        prev_wen    = 0;
        prev_stall  = 0;
        low_run     = 0;
        seen_pulse  = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycle(0, '0, 0);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (GAP + 3) cycle(0, '0, 0);
    endtask

    // Push one value into an idle block and check the two-edge latency.
    task automatic single_write(input logic [31:0] v, input logic [31:0] want_bus);
        int wc0;
        wc0 = exp_wc;
        cycle(1, v, 0);
        cycle(0, '0, 0);
        check("lat_after_t", smp_wen, 0);
        cycle(0, '0, 0);
        check("lat_after_t1", smp_wen, 0);
        cycle(0, '0, 0);
        check("lat_after_t2", smp_wen, 1);
        check("single_data", smp_data, want_bus);
        cycle(0, '0, 0);
        check("single_wen_1cyc", smp_wen, 0);
        check("single_wc", write_count, wc0 + 1);
    endtask

    initial begin
        int highs;
        int wc0;
        int k;
        int n;
        logic [31:0] fv [5];

        #2;
        do_reset();
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        check("ready_after_release", smp_ready, 1);

        // Single writes, both byte orders of interest
`ifdef RPT_BYTE_SWAP_EN
        single_write(32'd50, 32'h32000000);
        drain();
        single_write(32'h12345678, 32'h78563412);
`else
        single_write(32'd50, 32'd50);
        drain();
        single_write(32'h12345678, 32'h12345678);
`endif
        drain();

        // Stall held for 3 cycles in WRITE: wen high 4 cycles, one count
        wc0   = exp_wc;
        highs = 0;
        cycle(1, 32'd50, 1);
        repeat (2) cycle(0, '0, 1);
        repeat (3) begin
            cycle(0, '0, 1);
            if (smp_wen) begin
                highs++;
                check("stall_data", smp_data, exp_bus(32'd50));
            end
        end
        repeat (2) begin
            cycle(0, '0, 0);
            if (smp_wen) highs++;
        end
        check("stall_wen_cycles", highs, 4);
        check("stall_single_count", write_count, wc0 + 1);
        drain();

        // Fill: five back-to-back offers with the first write stalled
        for (int i = 0; i < 5; i++) fv[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            cycle(1, fv[i], 1);
            check("fill_accept", last_push, 1);
        end
        cycle(1, fv[4], 1);
        check("full_ready_low", smp_ready, 0);
        k = 0;
        while (!last_push && k < 50) begin
            cycle(1, fv[4], 0);
            k++;
        end
        check("fifth_accepted", last_push, 1);
        drain();
        check("fill_all_written", completions, 8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 9) < 3);
        end
        drain();

        // Reset during a stalled write with three more queued
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 1);
        check("pre_rst_wen", wen, 1);
        check("pre_rst_queued", exp_q.size(), 4);
        do_reset();
        cycle(0, '0, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_wc", write_count, 0);
        repeat (20) cycle(0, '0, 0);

        // Saturation of write_count
        n = 0;
        while (completions < 260 && n < 3000) begin
            cycle(1, $urandom, 0);
            n++;
        end
        check("sat_writes_done", completions >= 260, 1);
        drain();
        check("wc_saturated", write_count, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
